// File: rtl/db_strobe_gen.sv
// db_strobe_gen: turns each selected 6502 phi2 bus cycle into a set strobe,
// a dead-time-guarded buffer enable, and a read or write reset strobe.
// Every output comes straight from a flip-flop because the outputs drive an
// asynchronous latch.
module db_strobe_gen #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned DEAD_W  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic phi2,
    input  logic sel_n,
    input  logic rw,
    output logic s_n,
    output logic r1_n,
    output logic r2_n,
    output logic oe_n,
    output logic dir
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SET_PULSE = 3'd1,
        DEAD_ON   = 3'd2,
        ACTIVE    = 3'd3,
        DEAD_OFF  = 3'd4,
        RST_PULSE = 3'd5
    } state_t;

    // Counter values for the last cycle of a pulse or a dead interval.
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] DEAD_LAST  = 4'(DEAD_W - 1);

    logic       phi2_s1_q, phi2_s2_q, phi2_h_q;
    logic       rise, fall;
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       dir_q, dir_d;
    logic       s_n_q, s_n_d;
    logic       r1_n_q, r1_n_d;
    logic       r2_n_q, r2_n_d;
    logic       oe_n_q, oe_n_d;

    // Two-stage synchroniser for phi2 plus a history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phi2_s1_q <= 1'b0;
            phi2_s2_q <= 1'b0;
            phi2_h_q  <= 1'b0;
        end else begin
            phi2_s1_q <= phi2;
            phi2_s2_q <= phi2_s1_q;
            phi2_h_q  <= phi2_s2_q;
        end
    end

    assign rise = phi2_s2_q & ~phi2_h_q;
    assign fall = ~phi2_s2_q & phi2_h_q;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so the registered copies change together with the state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dir_d   = dir_q;
        s_n_d   = 1'b1;
        r1_n_d  = 1'b1;
        r2_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        case (state_q)
            IDLE: begin
                // A rise with sel_n high is simply not a cycle for us.
                if (rise && !sel_n) begin
                    state_d = SET_PULSE;
                    cnt_d   = 4'd0;
                    dir_d   = rw;
                    pend_d  = 1'b0;
                    s_n_d   = 1'b0;
                end
            end
            SET_PULSE: begin
                // A very short phi2 may end before the buffer is even enabled.
                if (fall) pend_d = 1'b1;
                if (cnt_q == PULSE_LAST) begin
                    state_d = DEAD_ON;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    s_n_d = 1'b0;
                end
            end
            DEAD_ON: begin
                if (cnt_q == DEAD_LAST) begin
                    cnt_d = 4'd0;
                    if (pend_q || fall) begin
                        // phi2 already ended: skip the enable entirely.
                        state_d = DEAD_OFF;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = ACTIVE;
                        oe_n_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (fall) pend_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (fall) begin
                    state_d = DEAD_OFF;
                    cnt_d   = 4'd0;
                    pend_d  = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            DEAD_OFF: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = RST_PULSE;
                    cnt_d   = 4'd0;
                    r1_n_d  = ~dir_q;
                    r2_n_d  = dir_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    r1_n_d = ~dir_q;
                    r2_n_d = dir_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                pend_d  = 1'b0;
            end
        endcase
    end

    // State, counter, pending flag and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            dir_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r1_n_q  <= 1'b1;
            r2_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            s_n_q   <= s_n_d;
            r1_n_q  <= r1_n_d;
            r2_n_q  <= r2_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    assign s_n  = s_n_q;
    assign r1_n = r1_n_q;
    assign r2_n = r2_n_q;
    assign oe_n = oe_n_q;
    assign dir  = dir_q;

endmodule
